// File: rtl/key_event_gen.sv
// key_event_gen: decodes PS/2 scan-code bytes into press/release events for one key
module key_event_gen #(
  parameter logic [8:0] KEY_CODE       = 9'h029,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         COUNT_BITS     = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [7:0]            din,
  input  logic                  din_valid,
  output logic                  keyPressed,
  output logic                  rise,
  output logic                  fall,
  output logic [COUNT_BITS-1:0] press_count,
  output logic                  seq_error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // bit0 marks an E0 prefix, bit1 marks an F0 prefix
  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] GOT_E0   = 2'b01;
  localparam logic [1:0] GOT_F0   = 2'b10;
  localparam logic [1:0] GOT_E0F0 = 2'b11;
  logic [1:0]            state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [COUNT_BITS-1:0] cnt_q, cnt_d;
  logic                  key_q, key_d, rise_q, rise_d, fall_q, fall_d, err_q, err_d;
  logic                  is_e0, is_f0, byte_c, hit, timeout;
  // prefix decoding, key matching, timeout supervision and next output values
  always_comb begin
    is_e0   = din == 8'hE0;
    is_f0   = din == 8'hF0;
    byte_c  = din_valid && !is_e0 && !is_f0;
    hit     = byte_c && ({state_q[0], din} == KEY_CODE);
    timeout = !din_valid && state_q != IDLE && tmr_q == TW'(TIMEOUT_CYCLES - 1);
    state_d = !din_valid ? (timeout ? IDLE : state_q) :
              is_e0 ? GOT_E0 : is_f0 ? {1'b1, state_q[0]} : IDLE;
    tmr_d   = (din_valid || state_q == IDLE || timeout) ? '0 : tmr_q + TW'(1);
    rise_d  = hit && !state_q[1] && !key_q;
    fall_d  = hit && state_q[1] && key_q;
    key_d   = key_q ? !fall_d : rise_d;
    cnt_d   = cnt_q + COUNT_BITS'(rise_d);
    err_d   = timeout;
  end
  // state and registered outputs; reset drops any partial prefix and releases the key
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      key_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      err_q   <= err_d;
    end
  end
  assign keyPressed  = key_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign press_count = cnt_q;
  assign seq_error   = err_q;
endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: scoreboard bench for key_event_gen with Space and extended-key instances
module tb_key_event_gen;
  localparam int TO = 20;
  typedef struct packed {logic [1:0] k; logic [7:0] c;} ev_t;
  logic clk = 0, resetN = 0, din_valid = 0;
  logic [7:0] din = 0;
  logic kp1, r1, f1, e1, kp2, r2, f2, e2;
  logic [7:0] c1, c2;
  int compared = 0, mismatched = 0;
  logic [7:0] exp1 = 0, exp2 = 0;
  ev_t q1[$], q2[$];
  always #5 clk = ~clk;
  key_event_gen #(.KEY_CODE(9'h029), .TIMEOUT_CYCLES(TO), .COUNT_BITS(8)) dut1 (
    .clk(clk), .resetN(resetN), .din(din), .din_valid(din_valid), .keyPressed(kp1),
    .rise(r1), .fall(f1), .press_count(c1), .seq_error(e1));
  key_event_gen #(.KEY_CODE(9'h175), .TIMEOUT_CYCLES(TO), .COUNT_BITS(8)) dut2 (
    .clk(clk), .resetN(resetN), .din(din), .din_valid(din_valid), .keyPressed(kp2),
    .rise(r2), .fall(f2), .press_count(c2), .seq_error(e2));
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic mon_chk(string n, logic r, logic f, logic e, logic kp, logic [7:0] c, ev_t x);
    ev_t a;
    a = {(r ? 2'd1 : f ? 2'd2 : 2'd3), c};
    compared++;
    if (a !== x || (r && f) || (r && !kp) || (f && kp)) begin
      mismatched++;
      $display("FAIL %s event: got kind %0d cnt %0d kp %b (r%b f%b e%b) expected kind %0d cnt %0d",
               n, a.k, a.c, kp, r, f, e, x.k, x.c);
    end
  endtask
  task automatic unexpected(string n, logic r, logic f, logic e);
    compared++;
    mismatched++;
    $display("FAIL %s event: got unexpected r%b f%b e%b expected none", n, r, f, e);
  endtask
  initial forever begin
    @(negedge clk);
    if (resetN) begin
      if (r1 | f1 | e1) begin
        if (q1.size() == 0) unexpected("dut1", r1, f1, e1);
        else mon_chk("dut1", r1, f1, e1, kp1, c1, q1.pop_front());
      end
      if (r2 | f2 | e2) begin
        if (q2.size() == 0) unexpected("dut2", r2, f2, e2);
        else mon_chk("dut2", r2, f2, e2, kp2, c2, q2.pop_front());
      end
    end
  end
  task automatic send(logic [7:0] b);
    @(negedge clk);
    din = b;
    din_valid = 1;
  endtask
  task automatic idle(int n);
    @(negedge clk);
    din_valid = 0;
    repeat (n - 1) @(negedge clk);
  endtask
  task automatic press1();
    exp1++;
    q1.push_back({2'd1, exp1});
    send(8'h29);
  endtask
  task automatic release1();
    q1.push_back({2'd2, exp1});
    send(8'hF0);
    send(8'h29);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_kp", kp1, 0);
    chk("reset_cnt", c1, 0);
    chk("reset_pulses", {r1, f1, e1, r2, f2, e2}, 0);
    resetN = 1;
    idle(2);
    press1();
    idle(1);
    chk("press_kp", kp1, 1);
    chk("press_cnt", c1, 1);
    release1();
    idle(1);
    chk("release_kp", kp1, 0);
    press1();
    send(8'h29);
    send(8'h29);
    idle(1);
    chk("typematic_kp", kp1, 1);
    chk("typematic_cnt", c1, 2);
    release1();
    idle(2);
    chk("typematic_release_kp", kp1, 0);
    exp2++;
    q2.push_back({2'd1, exp2});
    send(8'hE0); send(8'h75);
    idle(1);
    chk("ext_press_kp", kp2, 1);
    q2.push_back({2'd2, exp2});
    send(8'hE0); send(8'hF0); send(8'h75);
    idle(1);
    chk("ext_release_kp", kp2, 0);
    send(8'h75); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h29); send(8'hE0); send(8'hF0); send(8'h29);
    idle(2);
    chk("nonmatch_kp1", kp1, 0);
    chk("nonmatch_kp2", kp2, 0);
    chk("nonmatch_cnt1", c1, 2);
    chk("nonmatch_cnt2", c2, 1);
    q1.push_back({2'd3, exp1});
    q2.push_back({2'd3, exp2});
    send(8'hF0);
    idle(TO + 5);
    press1();
    idle(1);
    chk("after_timeout_kp", kp1, 1);
    release1();
    send(8'hF0); send(8'hE0); send(8'h29);
    idle(2);
    chk("restart_kp", kp1, 0);
    for (int i = 0; i < 253; i++) begin
      press1();
      idle(1);
      release1();
      idle(1);
    end
    idle(2);
    chk("wrap_cnt", c1, 0);
    press1();
    idle(2);
    chk("pre_reset_kp", kp1, 1);
    @(negedge clk);
    resetN = 0;
    #1;
    chk("async_reset_kp", kp1, 0);
    chk("async_reset_cnt", c1, 0);
    @(negedge clk);
    resetN = 1;
    exp1 = 0;
    idle(4);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
